// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-through bypass and per-register busy scoreboard.
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter bit BYPASS = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [AW-1:0] ra;
  logic [XLEN-1:0] d;
  logic b;
  // later write ports override earlier ones; the alloc is applied last so it wins over a write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && !(ZERO_REG && wr_addr[j*AW +: AW] == '0)) begin
          regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
          busy[wr_addr[j*AW +: AW]] <= 1'b0;
        end
      if (alloc_en && !(ZERO_REG && alloc_addr == '0)) busy[alloc_addr] <= 1'b1;
    end
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra = '0;
    d = '0;
    b = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      d = regs[ra];
      b = busy[ra];
      for (int j = 0; j < NWR; j++)
        if (BYPASS && !reset && wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
          d = wr_data[j*XLEN +: XLEN];
          b = 1'b0;
        end
      if (ZERO_REG && ra == '0) begin
        d = '0;
        b = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = d;
      rd_busy[i] = b;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks on two 32x32 configurations plus random traffic on a 16x64, 3R/2W instance.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [9:0]  a_rd_addr, a_wr_addr;
  logic [1:0]  a_wr_en;
  logic [63:0] a_wr_data;
  logic        a_alloc_en;
  logic [4:0]  a_alloc_addr;
  logic [63:0] d0_rd_data, d1_rd_data;
  logic [1:0]  d0_rd_busy, d1_rd_busy;

  logic [11:0]  b_rd_addr;
  logic [191:0] b_rd_data;
  logic [2:0]   b_rd_busy;
  logic [1:0]   b_wr_en;
  logic [7:0]   b_wr_addr;
  logic [127:0] b_wr_data;
  logic         b_alloc_en;
  logic [3:0]   b_alloc_addr;

  regfile_mp u0 (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(d0_rd_data), .rd_busy(d0_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr)
  );
  regfile_mp #(.BYPASS(1'b0), .ZERO_REG(1'b0)) u1 (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(d1_rd_data), .rd_busy(d1_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr)
  );
  regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3), .NWR(2)) u2 (
    .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] m_reg [16];
  bit m_busy [16];
  logic [3:0] ea;
  logic [63:0] ed;
  logic eb;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0;
    a_wr_en = '0;
    a_alloc_en = 1'b0;
  endtask

  function automatic logic [3:0] rnd_a();
    return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
  endfunction

  initial begin
    reset = 1'b1;
    {a_rd_addr, a_wr_addr, a_wr_en, a_wr_data, a_alloc_en, a_alloc_addr} = '0;
    {b_rd_addr, b_wr_en, b_wr_addr, b_wr_data, b_alloc_en, b_alloc_addr} = '0;
    for (int r = 0; r < 16; r++) begin
      m_reg[r] = '0;
      m_busy[r] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    idle();
    a_rd_addr = {5'd31, 5'd5};
    #1;
    chk("rst_u0_x5", d0_rd_data[31:0], 0);
    chk("rst_u0_x31", d0_rd_data[63:32], 0);
    chk("rst_u0_busy", d0_rd_busy, 0);
    chk("rst_u1_x5", d1_rd_data[31:0], 0);
    chk("rst_u1_x31", d1_rd_data[63:32], 0);
    chk("rst_u1_busy", d1_rd_busy, 0);
    @(negedge clk);
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd7};
    a_wr_data = {32'd0, 32'hDEADBEEF};
    a_rd_addr = {5'd0, 5'd7};
    #1;
    chk("byp_u0_x7", d0_rd_data[31:0], 32'hDEADBEEF);
    chk("nobyp_u1_x7", d1_rd_data[31:0], 0);
    @(negedge clk);
    idle();
    #1;
    chk("wr_u0_x7", d0_rd_data[31:0], 32'hDEADBEEF);
    chk("wr_u1_x7", d1_rd_data[31:0], 32'hDEADBEEF);
    @(negedge clk);
    a_wr_en = 2'b11;
    a_wr_addr = {5'd3, 5'd3};
    a_wr_data = {32'h22, 32'h11};
    a_rd_addr = {5'd7, 5'd3};
    #1;
    chk("conf_byp_u0_x3", d0_rd_data[31:0], 32'h22);
    @(negedge clk);
    idle();
    #1;
    chk("conf_u0_x3", d0_rd_data[31:0], 32'h22);
    chk("conf_u1_x3", d1_rd_data[31:0], 32'h22);
    @(negedge clk);
    a_alloc_en = 1'b1;
    a_alloc_addr = 5'd9;
    a_rd_addr = {5'd3, 5'd9};
    #1;
    chk("alloc_same_u0", d0_rd_busy[0], 0);
    chk("alloc_same_u1", d1_rd_busy[0], 0);
    @(negedge clk);
    idle();
    #1;
    chk("alloc_u0_busy", d0_rd_busy[0], 1);
    chk("alloc_u1_busy", d1_rd_busy[0], 1);
    @(negedge clk);
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd9};
    a_wr_data = {32'd0, 32'h55};
    #1;
    chk("wrclr_byp_u0", d0_rd_busy[0], 0);
    chk("wrclr_nobyp_u1", d1_rd_busy[0], 1);
    @(negedge clk);
    idle();
    #1;
    chk("wrclr_u0_busy", d0_rd_busy[0], 0);
    chk("wrclr_u1_busy", d1_rd_busy[0], 0);
    chk("wrclr_u0_x9", d0_rd_data[31:0], 32'h55);
    @(negedge clk);
    a_wr_en = 2'b01;
    a_alloc_en = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("allocwin_u0_busy", d0_rd_busy[0], 1);
    chk("allocwin_u1_busy", d1_rd_busy[0], 1);
    chk("allocwin_u0_x9", d0_rd_data[31:0], 32'h55);
    chk("allocwin_u1_x9", d1_rd_data[31:0], 32'h55);
    @(negedge clk);
    a_wr_en = 2'b10;
    a_wr_addr = {5'd0, 5'd0};
    a_wr_data = {32'hFFFF, 32'd0};
    a_alloc_en = 1'b1;
    a_alloc_addr = 5'd0;
    a_rd_addr = {5'd9, 5'd0};
    #1;
    chk("x0_same_u0", d0_rd_data[31:0], 0);
    chk("x0_same_u1", d1_rd_data[31:0], 0);
    @(negedge clk);
    idle();
    #1;
    chk("x0_u0_data", d0_rd_data[31:0], 0);
    chk("x0_u0_busy", d0_rd_busy[0], 0);
    chk("x0_u1_data", d1_rd_data[31:0], 32'hFFFF);
    chk("x0_u1_busy", d1_rd_busy[0], 1);
    @(negedge clk);
    a_alloc_en = 1'b1;
    a_alloc_addr = 5'd4;
    a_rd_addr = {5'd7, 5'd4};
    @(negedge clk);
    idle();
    reset = 1'b1;
    a_wr_en = 2'b01;
    a_wr_addr = {5'd0, 5'd4};
    a_wr_data = {32'd0, 32'h1234};
    a_alloc_en = 1'b1;
    #1;
    chk("rstcyc_u0_x4", d0_rd_data[31:0], 0);
    chk("rstcyc_u0_busy", d0_rd_busy[0], 1);
    chk("rstcyc_u0_x7", d0_rd_data[63:32], 32'hDEADBEEF);
    @(negedge clk);
    idle();
    #1;
    chk("rstmid_u0_x4", d0_rd_data[31:0], 0);
    chk("rstmid_u0_busy", d0_rd_busy, 0);
    chk("rstmid_u1_x4", d1_rd_data[31:0], 0);
    chk("rstmid_u1_busy", d1_rd_busy, 0);
    chk("rstmid_u0_x7", d0_rd_data[63:32], 0);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      b_wr_en = 2'($urandom);
      b_alloc_en = 1'($urandom);
      b_alloc_addr = rnd_a();
      for (int j = 0; j < 2; j++) begin
        b_wr_addr[j*4 +: 4] = rnd_a();
        b_wr_data[j*64 +: 64] = {$urandom, $urandom};
      end
      for (int i = 0; i < 3; i++) b_rd_addr[i*4 +: 4] = rnd_a();
      #1;
      for (int i = 0; i < 3; i++) begin
        ea = b_rd_addr[i*4 +: 4];
        ed = m_reg[ea];
        eb = m_busy[ea];
        for (int j = 0; j < 2; j++)
          if (!reset && b_wr_en[j] && b_wr_addr[j*4 +: 4] == ea) begin
            ed = b_wr_data[j*64 +: 64];
            eb = 1'b0;
          end
        if (ea == 0) begin
          ed = '0;
          eb = 1'b0;
        end
        chk($sformatf("rnd%0d_data%0d", c, i), b_rd_data[i*64 +: 64], ed);
        chk($sformatf("rnd%0d_busy%0d", c, i), 64'(b_rd_busy[i]), 64'(eb));
      end
      if (reset) begin
        for (int r = 0; r < 16; r++) begin
          m_reg[r] = '0;
          m_busy[r] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 2; j++)
          if (b_wr_en[j] && b_wr_addr[j*4 +: 4] != 0) begin
            m_reg[b_wr_addr[j*4 +: 4]] = b_wr_data[j*64 +: 64];
            m_busy[b_wr_addr[j*4 +: 4]] = 1'b0;
          end
        if (b_alloc_en && b_alloc_addr != 0) m_busy[b_alloc_addr] = 1'b1;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard. It is the integer register file for the pipelined core, serving decode/issue (read ports, allocate) and writeback (write ports). Register 0 is hardwired to zero when enabled. Reset is synchronous and clears all registers and busy bits in one cycle.

## Interface
Parameters:
- XLEN, 32, data width of each register
- NREGS, 32, number of registers (power of two, ≥ 2); AW = $clog2(NREGS) derived locally
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return the stored array value
- ZERO_REG, 1, 1 = register 0 reads zero, ignores writes and is never busy

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  reset, synchronous, active-high; clock clk
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has an outstanding producer
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses, packed like rd_addr
- wr_data  in  NWR*XLEN  write data, packed like rd_data
- alloc_en  in  1  mark alloc_addr busy (instruction issued with that destination)
- alloc_addr  in  AW  destination being allocated

## Operation
- Storage: NREGS x XLEN array plus NREGS busy bits.
- Reset (reset=1 at posedge): all registers go to 0 and all busy bits to 0. Writes and allocs in that cycle are ignored.
- Write: at posedge, if wr_en[j] is set, reg[wr_addr[j]] takes wr_data[j] and busy[wr_addr[j]] is cleared.
- Write conflict: if several enabled ports target the same address, the highest-index port wins (data and clear).
- Allocate: at posedge, if alloc_en is set, busy[alloc_addr] is set.
  - If an alloc and a write target the same address in the same cycle, the alloc wins: data is written and busy ends at 1.
- ZERO_REG=1:
  - Writes and allocs to address 0 are dropped.
  - rd_data for address 0 is 0 and rd_busy is 0, regardless of BYPASS.
- Read data (combinational):
  - BYPASS=1 and reset=0: if any enabled write port matches rd_addr[i], rd_data[i] is that port's wr_data (highest index wins). Otherwise it is reg[rd_addr[i]].
  - BYPASS=0, or reset=1: rd_data[i] = reg[rd_addr[i]].
- Busy (combinational):
  - rd_busy[i] = busy[rd_addr[i]].
  - With BYPASS=1 and reset=0, rd_busy[i] is forced to 0 when an enabled write matches rd_addr[i] in the same cycle.
  - Same-cycle alloc does not affect rd_busy; it is visible from the next cycle.
- Arithmetic: no width conversion. Addresses are used modulo NREGS.

## Timing
- Write latency: 1 cycle to the array. With BYPASS=1 it is 0 cycles to the read ports.
- Alloc latency: busy is visible on rd_busy 1 cycle after the alloc edge.
- Reset: rd_data is 0 for every address from the first edge with reset=1. It is undefined before the first reset.
- Reset mid-operation: a pending write in the reset cycle is lost and busy bits clear. Pipeline flush is the sequencer's responsibility.
- No internal FSM beyond the array and busy bits.
- Critical path: rd_addr/wr_addr compare, then the bypass mux, then rd_data. It scales with NWR.

## Test plan
- Reset, then read x5 on port 0 and x31 on port 1: both return 0x0, rd_busy=0.
- Write 0xDEADBEEF to x7 via port 0, with rd_addr[0]=7 in the same cycle:
  - BYPASS=1: returns 0xDEADBEEF immediately.
  - BYPASS=0: returns 0x0 that cycle and 0xDEADBEEF the next.
- Ports 0 and 1 both write x3, with 0x11 and 0x22: stored and bypassed value is 0x22.
- Alloc x9, then after 1 cycle rd_busy=1 for x9. Write 0x55 to x9: rd_busy=0 in the write cycle (BYPASS=1) and after. Alloc and write x9 in the same cycle: busy=1 afterward, data 0x55.
- With ZERO_REG=1, write 0xFFFF to x0 and alloc x0: x0 still reads 0 and is not busy. Repeat with ZERO_REG=0: reads 0xFFFF.
- Assert reset while a write of 0x1234 to x4 and an alloc of x4 are pending: x4=0 and busy=0 afterward. Random back-to-back traffic is checked against a reference model for NRD=3, NWR=2, NREGS=16, XLEN=64.
